dsp_pe_acc: RTL and testbench

Parametrised output-stationary MAC processing element, successor to the packed 8-bit DSP PE in the systolic array.
- Horizontal path: forwards one signed weight per cycle.
- Vertical path: forwards LANES packed signed activations per cycle.
- Each lane accumulates internally for a runtime-programmable number of MACs, then saturates the result and parks it in a one-deep result buffer.
- Results leave through a dedicated vertical drain shift chain, so activation streaming and result draining never share a bus.

---
 rtl/dsp_pe_acc.sv | 165 ++++++++++++++++
 tb/tb_dsp_pe_acc.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_pe_acc.sv
// Output-stationary MAC processing element: forwards weights east and packed activations south,
// accumulates LANES dot products, and hands saturated results to a separate vertical drain chain.
module dsp_pe_acc #(
  parameter int ACT_DW = 8,
  parameter int WGT_DW = 8,
  parameter int LANES  = 2,
  parameter int ACC_DW = 32,
  parameter int OUT_DW = 16,
  parameter int CNT_W  = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CNT_W-1:0]          k_len,
  input  logic                      clr,
  input  logic [WGT_DW-1:0]         left_in,
  input  logic                      left_vld,
  output logic [WGT_DW-1:0]         right_out,
  output logic                      right_vld,
  input  logic [LANES*ACT_DW-1:0]   top_in,
  input  logic                      top_vld,
  output logic [LANES*ACT_DW-1:0]   bottom_act,
  output logic                      bottom_act_vld,
  input  logic                      drain,
  input  logic [LANES*OUT_DW-1:0]   psum_in,
  input  logic                      psum_in_vld,
  output logic [LANES*OUT_DW-1:0]   psum_out,
  output logic                      psum_out_vld,
  output logic                      res_full,
  output logic                      ovf_err
);

  localparam int PROD_W = ACT_DW + WGT_DW;
  localparam logic signed [ACC_DW-1:0] SAT_HI = {{(ACC_DW-OUT_DW+1){1'b0}}, {(OUT_DW-1){1'b1}}};
  localparam logic signed [ACC_DW-1:0] SAT_LO = {{(ACC_DW-OUT_DW+1){1'b1}}, {(OUT_DW-1){1'b0}}};

  function automatic logic [OUT_DW-1:0] sat(input logic signed [ACC_DW-1:0] v);
    logic [OUT_DW-1:0] r;
    if (v > SAT_HI)      r = SAT_HI[OUT_DW-1:0];
    else if (v < SAT_LO) r = SAT_LO[OUT_DW-1:0];
    else                 r = v[OUT_DW-1:0];
    return r;
  endfunction

  logic [WGT_DW-1:0]        right_out_q;
  logic                     right_vld_q;
  logic [LANES*ACT_DW-1:0]  bottom_act_q;
  logic                     bottom_vld_q;
  logic [CNT_W-1:0]         k_cnt_q, k_cnt_d, k_last;
  logic                     fire, is_last;
  logic                     vld_p0_q, last_p0_q;
  logic                     vld_p1_q, last_p1_q;
  logic signed [PROD_W-1:0] prod_p1_d [LANES];
  logic signed [PROD_W-1:0] prod_p1_q [LANES];
  logic signed [ACC_DW-1:0] sum_p2    [LANES];
  logic signed [ACC_DW-1:0] acc_q     [LANES];
  logic [LANES*OUT_DW-1:0]  result_p2;
  logic                     cmpl_p2;
  logic [LANES*OUT_DW-1:0]  buf_q, buf_d, psum_out_q, psum_out_d;
  logic                     res_full_q, res_full_d, psum_vld_q, psum_vld_d, ovf_q, ovf_d;

  assign fire    = left_vld & top_vld;
  assign k_last  = (k_len == '0) ? '0 : k_len - 1'b1;
  assign is_last = (k_cnt_q >= k_last);

  always_comb begin
    k_cnt_d = k_cnt_q;
    if (clr)       k_cnt_d = '0;
    else if (fire) k_cnt_d = is_last ? '0 : k_cnt_q + 1'b1;
  end

  // Products are formed from the forwarded operand registers, one cycle after the fire.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      prod_p1_d[l] = PROD_W'($signed(bottom_act_q[l*ACT_DW +: ACT_DW])) *
                     PROD_W'($signed(right_out_q));
    end
  end

  always_comb begin
    result_p2 = '0;
    for (int l = 0; l < LANES; l++) begin
      sum_p2[l] = acc_q[l] + ACC_DW'(prod_p1_q[l]);
      result_p2[l*OUT_DW +: OUT_DW] = sat(sum_p2[l]);
    end
  end

  assign cmpl_p2 = vld_p1_q & last_p1_q & ~clr;

  // A completion coinciding with a drain wins the buffer; the incoming chain word is lost.
  always_comb begin
    buf_d      = buf_q;
    res_full_d = res_full_q;
    psum_out_d = psum_out_q;
    psum_vld_d = 1'b0;
    ovf_d      = ovf_q;
    if (drain) begin
      psum_out_d = buf_q;
      psum_vld_d = res_full_q;
      buf_d      = psum_in;
      res_full_d = psum_in_vld;
    end
    if (cmpl_p2) begin
      buf_d      = result_p2;
      res_full_d = 1'b1;
      if (drain ? psum_in_vld : res_full_q) ovf_d = 1'b1;
    end
    if (clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      right_out_q  <= '0;
      right_vld_q  <= 1'b0;
      bottom_act_q <= '0;
      bottom_vld_q <= 1'b0;
      k_cnt_q      <= '0;
      vld_p0_q     <= 1'b0;
      last_p0_q    <= 1'b0;
      vld_p1_q     <= 1'b0;
      last_p1_q    <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        prod_p1_q[l] <= '0;
        acc_q[l]     <= '0;
      end
      buf_q        <= '0;
      res_full_q   <= 1'b0;
      psum_out_q   <= '0;
      psum_vld_q   <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      // p0: operand capture and fire tagging
      right_out_q  <= left_in;
      right_vld_q  <= left_vld;
      bottom_act_q <= top_in;
      bottom_vld_q <= top_vld;
      k_cnt_q      <= k_cnt_d;
      vld_p0_q     <= fire & ~clr;
      last_p0_q    <= is_last;
      // p1: product register
      vld_p1_q     <= vld_p0_q & ~clr;
      last_p1_q    <= last_p0_q;
      for (int l = 0; l < LANES; l++) prod_p1_q[l] <= prod_p1_d[l];
      // p2: accumulate, or retire into the result buffer
      for (int l = 0; l < LANES; l++) begin
        if (clr)                      acc_q[l] <= '0;
        else if (vld_p1_q)            acc_q[l] <= last_p1_q ? '0 : sum_p2[l];
      end
      buf_q        <= buf_d;
      res_full_q   <= res_full_d;
      psum_out_q   <= psum_out_d;
      psum_vld_q   <= psum_vld_d;
      ovf_q        <= ovf_d;
    end
  end

  assign right_out      = right_out_q;
  assign right_vld      = right_vld_q;
  assign bottom_act     = bottom_act_q;
  assign bottom_act_vld = bottom_vld_q;
  assign psum_out       = psum_out_q;
  assign psum_out_vld   = psum_vld_q;
  assign res_full       = res_full_q;
  assign ovf_err        = ovf_q;

endmodule

// File: tb/tb_dsp_pe_acc.sv
// Directed bench for dsp_pe_acc: a reference MAC model pushes expected results to a scoreboard
// at fire time; they are popped and compared as the drain chain delivers them.
module tb_dsp_pe_acc;
  localparam int ACT_DW = 8;
  localparam int WGT_DW = 8;
  localparam int LANES  = 2;
  localparam int ACC_DW = 32;
  localparam int OUT_DW = 16;
  localparam int CNT_W  = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst_n, clr, left_vld, top_vld, drain, psum_in_vld;
  logic [CNT_W-1:0]         k_len;
  logic [WGT_DW-1:0]        left_in, right_out;
  logic                     right_vld, bottom_act_vld, psum_out_vld, res_full, ovf_err;
  logic [LANES*ACT_DW-1:0]  top_in, bottom_act;
  logic [LANES*OUT_DW-1:0]  psum_in, psum_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];
  int m0, m1, mk;

  dsp_pe_acc #(.ACT_DW(ACT_DW), .WGT_DW(WGT_DW), .LANES(LANES), .ACC_DW(ACC_DW),
               .OUT_DW(OUT_DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .k_len(k_len), .clr(clr),
    .left_in(left_in), .left_vld(left_vld), .right_out(right_out), .right_vld(right_vld),
    .top_in(top_in), .top_vld(top_vld), .bottom_act(bottom_act), .bottom_act_vld(bottom_act_vld),
    .drain(drain), .psum_in(psum_in), .psum_in_vld(psum_in_vld),
    .psum_out(psum_out), .psum_out_vld(psum_out_vld), .res_full(res_full), .ovf_err(ovf_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat16(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic logic [31:0] pack_res(input int r0, input int r1);
    logic [31:0] p;
    p[15:0]  = r0[15:0];
    p[31:16] = r1[15:0];
    return p;
  endfunction

  function automatic logic [15:0] pack_act(input int a0, input int a1);
    logic [15:0] p;
    p[7:0]  = a0[7:0];
    p[15:8] = a1[7:0];
    return p;
  endfunction

  task automatic model_clear();
    m0 = 0; m1 = 0; mk = 0;
  endtask

  // One cycle of stimulus; the model retires a result on the last joint fire.
  task automatic drive(input bit lv, input bit tv, input int a0, input int a1, input int w, input bit c);
    int kmax;
    logic [7:0] w8;
    logic [15:0] act;
    w8  = w[7:0];
    act = pack_act(a0, a1);
    left_vld = lv; top_vld = tv; left_in = w8; top_in = act; clr = c;
    kmax = (k_len == 0) ? 1 : int'(k_len);
    if (c) model_clear();
    else if (lv && tv) begin
      m0 += a0 * w;
      m1 += a1 * w;
      if (mk == kmax - 1) begin
        sb.push_back(pack_res(sat16(m0), sat16(m1)));
        model_clear();
      end else mk++;
    end
    tick();
    check("fwd_wgt", right_out, w8);
    check("fwd_wvld", right_vld, lv);
    check("fwd_act", bottom_act, act);
    check("fwd_avld", bottom_act_vld, tv);
    clr = 0; left_vld = 0; top_vld = 0;
  endtask

  task automatic do_drain(input string tag, input int p0, input int p1, input bit pv);
    logic [31:0] exp;
    drain = 1; psum_in = pack_res(p0, p1); psum_in_vld = pv;
    tick();
    drain = 0; psum_in_vld = 0;
    exp = (sb.size() > 0) ? sb.pop_front() : 'x;
    check(tag, psum_out, exp);
    check({tag, "_vld"}, psum_out_vld, 1'b1);
  endtask

  initial begin
    rst_n = 0; clr = 0; left_vld = 0; top_vld = 0; drain = 0; psum_in_vld = 0;
    left_in = '0; top_in = '0; psum_in = '0; k_len = 10'd4;
    model_clear();
    #12;
    check("rst_right_out", right_out, 0);
    check("rst_right_vld", right_vld, 0);
    check("rst_bottom_act", bottom_act, 0);
    check("rst_bottom_vld", bottom_act_vld, 0);
    check("rst_psum_out", psum_out, 0);
    check("rst_psum_vld", psum_out_vld, 0);
    check("rst_res_full", res_full, 0);
    check("rst_ovf", ovf_err, 0);
    rst_n = 1;
    tick();

    // Basic accumulation and result latency
    repeat (4) drive(1, 1, 10, -5, 3, 0);
    check("t1_full_t0", res_full, 0);
    tick();
    check("t1_full_t1", res_full, 0);
    tick();
    check("t1_full_t2", res_full, 1);
    check("t1_ovf", ovf_err, 0);

    // Drain shifts the buffer out and the north word in
    sb.push_back(pack_res(5, 7));
    do_drain("t1_drain", 5, 7, 1);
    check("t1_drain_full", res_full, 1);
    tick();
    check("t1_hold_vld", psum_out_vld, 0);
    check("t1_hold_data", psum_out, pack_res(120, -60));
    do_drain("t1_drain2", 0, 0, 0);
    check("t1_empty", res_full, 0);

    // Saturation, then a fresh accumulation after retirement
    repeat (4) drive(1, 1, 127, -128, 127, 0);
    tick(); tick();
    check("sat_full", res_full, 1);
    do_drain("sat", 0, 0, 0);
    repeat (4) drive(1, 1, 0, 0, 127, 0);
    tick(); tick();
    do_drain("sat_zero", 0, 0, 0);

    // Valid gaps: only joint fires count
    k_len = 10'd3;
    for (int i = 0; i < 6; i++)
      drive(i % 2 == 0, 1, 3 * i + 1, -(i + 2), (i % 4 == 0) ? -(i + 2) : (i + 2), 0);
    check("gap_full_t1", res_full, 0);
    tick();
    check("gap_full_t2", res_full, 1);
    do_drain("gap", 0, 0, 0);

    // Overrun with k_len=1 and no drain
    k_len = 10'd1;
    drive(1, 1, 2, 3, 4, 0);
    drive(1, 1, 1, -1, 5, 0);
    tick();
    check("ovr_full", res_full, 1);
    check("ovr_ovf_first", ovf_err, 0);
    tick();
    check("ovr_ovf", ovf_err, 1);
    void'(sb.pop_front());
    do_drain("ovr", 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    check("ovr_clr", ovf_err, 0);

    // clr in the same cycle as a fire drops it
    drive(1, 1, 9, 9, 9, 1);
    tick(); tick(); tick();
    check("clr_drop", res_full, 0);

    // Completion coinciding with a drain carrying valid north data
    drive(1, 1, 3, 3, 2, 0);
    drive(1, 1, 4, -2, 3, 0);
    tick();
    check("sim_full", res_full, 1);
    check("sim_ovf0", ovf_err, 0);
    do_drain("sim", 9, 9, 1);
    check("sim_ovf", ovf_err, 1);
    check("sim_full2", res_full, 1);
    drive(0, 0, 0, 0, 0, 1);
    check("sim_clr_ovf", ovf_err, 0);
    check("sim_clr_full", res_full, 1);
    do_drain("sim2", 0, 0, 0);
    check("sim_empty", res_full, 0);

    // Asynchronous reset mid-accumulation
    k_len = 10'd4;
    drive(1, 1, 50, 50, 2, 0);
    drive(1, 1, 50, 50, 2, 0);
    #2;
    rst_n = 0;
    #1;
    check("arst_right_vld", right_vld, 0);
    check("arst_right_out", right_out, 0);
    check("arst_bottom_act", bottom_act, 0);
    check("arst_psum_out", psum_out, 0);
    check("arst_res_full", res_full, 0);
    model_clear();
    #2;
    rst_n = 1;
    repeat (4) drive(1, 1, 1, 2, 3, 0);
    tick();
    check("arst_full_t1", res_full, 0);
    tick();
    check("arst_full_t2", res_full, 1);
    check("arst_ovf", ovf_err, 0);
    do_drain("arst_fresh", 0, 0, 0);
    check("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
